instr_fetch_unit: RTL and testbench

//  Fetch stage feeding decode and the immediate extender. Holds the PC, issues word reads to

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit_next_pc_sel.sv | 25 ++
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: pc_src encodings, fetch FSM states,
// and the canonical NOP.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: word request/address out, data/ready back.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection: sequential, PC-relative branch/JAL, or JALR target, plus the
// alignment check that decides whether fetch may continue.
module next_pc_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_src)
      PC_BRANCH: next_pc = pc + imm_ext;
      // JALR drops bit 0 before alignment is judged, so only bit 1 can fault.
      PC_JALR:   next_pc = alu_result & ~32'd1;
      default:   ;
    endcase
    misaligned = next_pc[1];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory, and holds the fetched
// instruction stable for decode until it is released.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        imem,
  input  logic                      stall,
  input  logic [1:0]                pc_src,
  input  logic [XLEN-1:0]           imm_ext,
  input  logic [XLEN-1:0]           alu_result,
  output logic [XLEN-1:0]           instr,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           pc_plus4,
  output logic                      instr_valid,
  output logic                      fetch_fault
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc_d, instr_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  next_pc_sel u_next_pc_sel (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_next;
      pc    <= pc_d;
      instr <= instr_d;
    end
  end

  always_comb begin
    state_next    = state;
    pc_d          = pc;
    instr_d       = instr;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    fetch_fault   = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          instr_d    = imem.imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d       = next_pc;
          state_next = misaligned ? FAULT : FETCH;
        end
      end
      FAULT: fetch_fault = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a PC/instruction reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext, alu_result;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_fault;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .stall       (stall),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  // Reference: target address from the architectural rules.
  function automatic logic [31:0] model_target(logic [31:0] cur, logic [1:0] src,
                                               logic [31:0] imm, logic [31:0] alu);
    case (src)
      2'd1:    return cur + imm;
      2'd2:    return alu - (alu % 2);
      default: return cur + 32'd4;
    endcase
  endfunction

  function automatic bit model_fault(logic [31:0] a);
    return (a % 4) >= 2;
  endfunction

  // Stimulus only: release a HOLD with the given selection, then re-assert stall.
  task automatic step(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    exp_pc     = model_target(exp_pc, src, imm, alu);
    stall      = 1'b0;
    pc_src     = src;
    imm_ext    = imm;
    alu_result = alu;
    @(negedge clk);
    stall      = 1'b1;
    pc_src     = 2'($urandom_range(3, 0));
    imm_ext    = $urandom;
    alu_result = $urandom;
  endtask

  // Stimulus only: answer the pending fetch in this cycle.
  task automatic give_data(input logic [31:0] d);
    exp_instr           = d;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = d;
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = $urandom;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b1; pc_src = 2'd0; imm_ext = '0; alu_result = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_idle_req: got %b want 0", imem_bus.imem_req); end
    @(negedge clk);
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL rst_fetch_req: got %b want 1", imem_bus.imem_req); end
    // Reset asserted mid-FETCH with a response on the bus; it must be discarded.
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_async_req: got %b want 0", imem_bus.imem_req); end
    checks++; if (pc !== RST_PC) begin failures++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
    checks++; if (instr !== NOP_INSTR) begin failures++; $display("FAIL rst_instr: got %h want %h", instr, NOP_INSTR); end
    checks++; if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_flags: got valid=%b fault=%b want 0 0", instr_valid, fetch_fault); end
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst2_idle_req: got %b want 0", imem_bus.imem_req); end
    @(negedge clk);
    checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) begin failures++; $display("FAIL rst2_fetch: got req=%b addr=%h want 1 %h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC); end
    checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR) begin failures++; $display("FAIL rst2_discard: got valid=%b instr=%h want 0 %h", instr_valid, instr, NOP_INSTR); end
    exp_pc = RST_PC;
    exp_instr = NOP_INSTR;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_pc) begin failures++; $display("FAIL seq_fetch%0d: got req=%b addr=%h want 1 %h", i, imem_bus.imem_req, imem_bus.imem_addr, exp_pc); end
      give_data($urandom);
      checks++; if (instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL seq_hold%0d: got valid=%b req=%b want 1 0", i, instr_valid, imem_bus.imem_req); end
      checks++; if (instr !== exp_instr || pc !== exp_pc) begin failures++; $display("FAIL seq_data%0d: got instr=%h pc=%h want %h %h", i, instr, pc, exp_instr, exp_pc); end
      checks++; if (pc_plus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL seq_plus4_%0d: got %h want %h", i, pc_plus4, exp_pc + 32'd4); end
      if (i < 2) step(2'd0, $urandom, $urandom);
    end
  endtask

  task automatic test_branch;
    step(2'd0, $urandom, $urandom);
    give_data($urandom);
    step(2'd0, $urandom, $urandom);
    give_data($urandom);
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL br_setup_pc: got %h want 00000010", pc); end
    step(2'd1, 32'hFFFF_FFF8, $urandom);
    checks++; if (imem_bus.imem_addr !== 32'h8 || imem_bus.imem_req !== 1'b1 || fetch_fault !== 1'b0) begin failures++; $display("FAIL br_target: got addr=%h req=%b fault=%b want 00000008 1 0", imem_bus.imem_addr, imem_bus.imem_req, fetch_fault); end
    give_data($urandom);
    step(2'd2, $urandom, 32'h0000_0101);
    checks++; if (imem_bus.imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin failures++; $display("FAIL jalr_target: got addr=%h fault=%b want 00000100 0", imem_bus.imem_addr, fetch_fault); end
    give_data($urandom);
  endtask

  task automatic test_stall;
    for (int k = 0; k < 5; k++) begin
      pc_src = 2'($urandom_range(3, 0)); imm_ext = $urandom; alu_result = $urandom;
      imem_bus.imem_ready = 1'($urandom_range(1, 0)); imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      checks++; if (instr !== exp_instr || pc !== exp_pc || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold%0d: got instr=%h pc=%h valid=%b req=%b want %h %h 1 0", k, instr, pc, instr_valid, imem_bus.imem_req, exp_instr, exp_pc); end
    end
    imem_bus.imem_ready = 1'b0;
    step(2'd0, $urandom, $urandom);
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_pc || instr_valid !== 1'b0) begin failures++; $display("FAIL mem_wait%0d: got req=%b addr=%h valid=%b want 1 %h 0", k, imem_bus.imem_req, imem_bus.imem_addr, instr_valid, exp_pc); end
      stall = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    stall = 1'b1;
    give_data($urandom);
    checks++; if (instr !== exp_instr || instr_valid !== 1'b1) begin failures++; $display("FAIL mem_wait_data: got instr=%h valid=%b want %h 1", instr, instr_valid, exp_instr); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      logic [1:0]  src;
      logic [31:0] imm, alu;
      int          s;
      int unsigned w;
      src = 2'($urandom_range(3, 0));
      s   = int'($urandom_range(255, 0)) - 128;
      imm = 32'(s * 4);
      alu = ($urandom & ~32'd3) | 32'($urandom_range(1, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      step(src, imm, alu);
      checks++; if (imem_bus.imem_addr !== exp_pc || imem_bus.imem_req !== 1'b1 || fetch_fault !== 1'b0) begin failures++; $display("FAIL rnd_addr%0d: got addr=%h req=%b fault=%b want %h 1 0", n, imem_bus.imem_addr, imem_bus.imem_req, fetch_fault, exp_pc); end
      w = $urandom_range(3, 0);
      repeat (w) @(negedge clk);
      give_data($urandom);
      checks++; if (instr !== exp_instr || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4 || instr_valid !== 1'b1) begin failures++; $display("FAIL rnd_hold%0d: got instr=%h pc=%h p4=%h valid=%b want %h %h %h 1", n, instr, pc, pc_plus4, instr_valid, exp_instr, exp_pc, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_wrap;
    step(2'd2, $urandom, 32'hFFFF_FFFD);
    checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup: got %h want fffffffc", imem_bus.imem_addr); end
    give_data($urandom);
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
    step(2'd0, $urandom, $urandom);
    checks++; if (imem_bus.imem_addr !== 32'h0 || fetch_fault !== 1'b0 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL wrap_next: got addr=%h fault=%b req=%b want 00000000 0 1", imem_bus.imem_addr, fetch_fault, imem_bus.imem_req); end
    give_data($urandom);
  endtask

  task automatic test_fault;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL flt_setup_pc: got %h want 00000000", pc); end
    step(2'd1, 32'h6, $urandom);
    checks++; if (model_fault(exp_pc) && (fetch_fault !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0)) begin failures++; $display("FAIL flt_enter: got fault=%b req=%b valid=%b want 1 0 0", fetch_fault, imem_bus.imem_req, instr_valid); end
    checks++; if (pc !== exp_pc) begin failures++; $display("FAIL flt_pc: got %h want %h", pc, exp_pc); end
    for (int k = 0; k < 4; k++) begin
      imem_bus.imem_ready = 1'($urandom_range(1, 0));
      stall = 1'($urandom_range(1, 0));
      @(negedge clk);
      checks++; if (fetch_fault !== 1'b1 || imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL flt_sticky%0d: got fault=%b req=%b want 1 0", k, fetch_fault, imem_bus.imem_req); end
    end
    imem_bus.imem_ready = 1'b0; stall = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (fetch_fault !== 1'b0 || pc !== RST_PC) begin failures++; $display("FAIL flt_clear: got fault=%b pc=%h want 0 %h", fetch_fault, pc, RST_PC); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) begin failures++; $display("FAIL flt_restart: got req=%b addr=%h want 1 %h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_random();
    test_wrap();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
